// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM states, default sizes and clog2 helper; PARITY state exists only with SCAN_PARITY_EN
package scan_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NUM_CHAINS = 4;
`ifdef SCAN_PARITY_EN
  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, PARITY, UPDATE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, UPDATE} state_t;
`endif
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/chain_shadow.sv
// chain_shadow: WIDTH-wide update register with sync reset and write enable
module chain_shadow #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/scan_chain_controller.sv
// scan_chain_controller: capture-shift-update sequencer over NUM_CHAINS shadow chains
// Define SCAN_PARITY_EN to check an even-parity bit after SHIFT before committing.
module scan_chain_controller
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CHAINS = DEF_NUM_CHAINS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [clog2(NUM_CHAINS)-1:0] chain_sel,
  input  logic                        tdi,
  input  logic [WIDTH*NUM_CHAINS-1:0] cap_data,
  output logic                        tdo,
  output logic [WIDTH*NUM_CHAINS-1:0] upd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        parity_err
);
  localparam int SW = clog2(NUM_CHAINS);
  localparam int CW = clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sel;
  logic accept, commit, last;
  assign accept = state == IDLE && start && !abort;
  assign commit = state == UPDATE && !abort;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign tdo = state == SHIFT ? sr[WIDTH-1] : 1'b0;
`ifdef SCAN_PARITY_EN
  logic par, perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CAPTURE : IDLE;
      CAPTURE: state_n = SHIFT;
`ifdef SCAN_PARITY_EN
      SHIFT:   state_n = last ? PARITY : SHIFT;
      PARITY:  state_n = tdi == par ? UPDATE : IDLE;
`else
      SHIFT:   state_n = last ? UPDATE : SHIFT;
`endif
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      sel <= '0;
      done <= 1'b0;
`ifdef SCAN_PARITY_EN
      par <= 1'b0;
      perr <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done <= commit;
      if (accept) sel <= chain_sel;
      if (state == CAPTURE) begin
        sr <= cap_data[int'(sel)*WIDTH +: WIDTH];
        cnt <= '0;
      end
      if (state == SHIFT) begin
        sr <= {sr[WIDTH-2:0], tdi};
        cnt <= cnt + 1'b1;
      end
`ifdef SCAN_PARITY_EN
      if (accept) perr <= 1'b0;
      if (state == CAPTURE) par <= 1'b0;
      if (state == SHIFT) par <= par ^ tdi;
      if (state == PARITY && !abort && tdi != par) perr <= 1'b1;
`endif
    end
  end
  for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain
    chain_shadow #(.WIDTH(WIDTH)) u_shadow (
      .clk  (clk),
      .reset(reset),
      .we   (commit && sel == SW'(k)),
      .d    (sr),
      .q    (upd_data[k*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_scan_chain_controller.sv
// tb_scan_chain_controller: randomized transactions checked against a per-chain byte model
module tb_scan_chain_controller;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 0, reset, start, abort, tdi, tdo, busy, done, parity_err;
  logic [1:0] chain_sel;
  logic [W*N-1:0] cap_data, upd_data;
  logic [W-1:0] model [N];
  logic perr_m;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  scan_chain_controller #(.WIDTH(W), .NUM_CHAINS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .chain_sel(chain_sel),
    .tdi(tdi), .cap_data(cap_data), .tdo(tdo), .upd_data(upd_data),
    .busy(busy), .done(done), .parity_err(parity_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [W*N-1:0] model_bus();
    logic [W*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = model[k];
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int ch, input logic [W-1:0] capv, input logic [W-1:0] tdiv,
                     input int ab, input bit spur, input logic pbit);
    cap_data = $urandom;
    cap_data[ch*W +: W] = capv;
    chain_sel = 2'(ch);
    start = 1;
    step();
    start = 0;
    perr_m = 0;
    chain_sel = 2'($urandom);
    chk("cap_busy", busy, 1);
    chk("cap_tdo", tdo, 0);
    step();
    cap_data = $urandom;
    for (int i = 0; i < W; i++) begin
      chk("shift_tdo", tdo, capv[W-1-i]);
      chk("shift_busy", busy, 1);
      tdi = tdiv[W-1-i];
      if (spur && i == 3) begin
        start = 1;
        chain_sel = 2'((ch + 1) % N);
      end
      if (i == ab) abort = 1;
      step();
      start = 0;
      abort = 0;
      if (i == ab) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_upd", upd_data, model_bus());
        step();
        chk("abort_nodone", done, 0);
        return;
      end
    end
    tdi = pbit;
`ifdef SCAN_PARITY_EN
    chk("par_done", done, 0);
    chk("par_tdo", tdo, 0);
    step();
    if (pbit != ^tdiv) begin
      perr_m = 1;
      chk("perr_done", done, 0);
      chk("perr_busy", busy, 0);
      chk("perr_flag", parity_err, perr_m);
      chk("perr_upd", upd_data, model_bus());
      step();
      chk("perr_nodone", done, 0);
      return;
    end
`endif
    chk("upd_early_done", done, 0);
    chk("upd_busy", busy, 1);
    step();
    model[ch] = tdiv;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_upd", upd_data, model_bus());
    chk("done_perr", parity_err, perr_m);
    step();
    chk("done_pulse", done, 0);
  endtask
  initial begin
    reset = 1; start = 0; abort = 0; tdi = 0; chain_sel = 0; cap_data = '0;
    for (int k = 0; k < N; k++) model[k] = '0;
    perr_m = 0;
    step();
    step();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tdo", tdo, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_upd", upd_data, 0);
    run(2, 8'hA5, 8'h3C, -1, 0, 1'b0);
    chk("dir_upd", upd_data, 32'h003C_0000);
    run(0, 8'($urandom), 8'h5A, -1, 1, 1'b0);
    run(1, 8'($urandom), 8'($urandom), 3, 0, 1'b0);
    start = 1; abort = 1; chain_sel = 1;
    step();
    start = 0; abort = 0;
    chk("idle_abort_busy", busy, 0);
    step();
    chk("idle_abort_busy2", busy, 0);
    for (int t = 0; t < 24; t++) begin
      logic [W-1:0] dv;
      int ab;
      dv = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run(int'($urandom_range(0, N - 1)), 8'($urandom), dv, ab, bit'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? ~^dv : ^dv);
    end
`ifdef SCAN_PARITY_EN
    run(1, 8'($urandom), 8'h3C, -1, 0, 1'b1);
    run(1, 8'($urandom), 8'h3C, -1, 0, 1'b0);
`endif
    run(3, 8'($urandom), 8'h3C, -1, 0, 1'b0);
    chain_sel = 3; start = 1;
    step();
    start = 0;
    step();
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    for (int k = 0; k < N; k++) model[k] = '0;
    perr_m = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_upd", upd_data, 0);
    chk("midrst_done", done, 0);
    run(2, 8'($urandom), 8'($urandom), -1, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
